// File: rtl/seg_monitor_pkg.sv
// Shared constants for the 7-segment monitor: segment geometry and the
// active-high gfedcba patterns for hex digits 0..F.
package seg_monitor_pkg;

    localparam int SEG_WIDTH = 7;

    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F_BIT = 5;
    localparam int SEG_G = 6;

    localparam logic [SEG_WIDTH-1:0] SEG_0 = 7'h3F;
    localparam logic [SEG_WIDTH-1:0] SEG_1 = 7'h06;
    localparam logic [SEG_WIDTH-1:0] SEG_2 = 7'h5B;
    localparam logic [SEG_WIDTH-1:0] SEG_3 = 7'h4F;
    localparam logic [SEG_WIDTH-1:0] SEG_4 = 7'h66;
    localparam logic [SEG_WIDTH-1:0] SEG_5 = 7'h6D;
    localparam logic [SEG_WIDTH-1:0] SEG_6 = 7'h7D;
    localparam logic [SEG_WIDTH-1:0] SEG_7 = 7'h07;
    localparam logic [SEG_WIDTH-1:0] SEG_8 = 7'h7F;
    localparam logic [SEG_WIDTH-1:0] SEG_9 = 7'h6F;
    localparam logic [SEG_WIDTH-1:0] SEG_A_HEX = 7'h77;
    localparam logic [SEG_WIDTH-1:0] SEG_B_HEX = 7'h7C;
    localparam logic [SEG_WIDTH-1:0] SEG_C_HEX = 7'h39;
    localparam logic [SEG_WIDTH-1:0] SEG_D_HEX = 7'h5E;
    localparam logic [SEG_WIDTH-1:0] SEG_E_HEX = 7'h79;
    localparam logic [SEG_WIDTH-1:0] SEG_F = 7'h71;

    // Map a raw bus to active-high form so decoding has one table.
    function automatic logic [SEG_WIDTH-1:0] seg_normalize(
        input logic [SEG_WIDTH-1:0] raw,
        input logic                 active_low
    );
        return active_low ? ~raw : raw;
    endfunction

endpackage

// File: rtl/seg_monitor_seg7_decode.sv
// Combinational decode of one active-high 7-segment pattern to a hex nibble;
// any pattern outside the sixteen hex glyphs reports valid = 0.
module seg7_decode
    import seg_monitor_pkg::*;
(
    input  logic [SEG_WIDTH-1:0] pattern,
    output logic                 valid,
    output logic [3:0]           nibble
);

    always_comb begin
        valid  = 1'b1;
        nibble = 4'h0;
        case (pattern)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_A_HEX: nibble = 4'hA;
            SEG_B_HEX: nibble = 4'hB;
            SEG_C_HEX: nibble = 4'hC;
            SEG_D_HEX: nibble = 4'hD;
            SEG_E_HEX: nibble = 4'hE;
            SEG_F:     nibble = 4'hF;
            default:   valid  = 1'b0;
        endcase
    end

endmodule

// File: rtl/seg_monitor.sv
// Turns four 7-segment digit buses back into a 16-bit word, commits each new
// stable value, and queues commits in a small FIFO for a downstream consumer.
module seg_monitor
    import seg_monitor_pkg::*;
#(
    parameter int STABLE_CYCLES  = 3,
    parameter int DEPTH          = 4,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  seg0,
    input  logic [6:0]  seg1,
    input  logic [6:0]  seg2,
    input  logic [6:0]  seg3,
    output logic [15:0] value,
    output logic        value_valid,
    output logic        bad_pattern,
    output logic [15:0] rd_data,
    output logic        rd_valid,
    input  logic        rd_ready,
    output logic [7:0]  overflow_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [3:0]    STC  = 4'(STABLE_CYCLES);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [4*SEG_WIDTH-1:0] seg_in;
    logic [4*SEG_WIDTH-1:0] s_seg;
    logic [3:0]             dig_valid;
    logic [15:0]            word;
    logic                   word_ok;
    logic                   same;
    logic [3:0]             stable_cnt;
    logic [3:0]             cnt_next;
    logic                   commit;

    assign seg_in = {seg3, seg2, seg1, seg0};

    for (genvar i = 0; i < 4; i++) begin : g_dec
        seg7_decode u_dec (
            .pattern(seg_normalize(s_seg[i*SEG_WIDTH +: SEG_WIDTH], SEG_ACTIVE_LOW != 0)),
            .valid  (dig_valid[i]),
            .nibble (word[i*4 +: 4])
        );
    end

    assign word_ok = &dig_valid;
    // The sample arriving at this edge is compared with the one already held,
    // so the count reaches STABLE_CYCLES on the STABLE_CYCLES-th repeat.
    assign same    = (seg_in == s_seg);

    always_comb begin
        cnt_next = 4'd0;
        if (word_ok && same) begin
            cnt_next = (stable_cnt == STC) ? stable_cnt : stable_cnt + 4'd1;
        end
    end

    assign commit = (cnt_next == STC) && (!value_valid || (word != value));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_seg       <= '0;
            stable_cnt  <= 4'd0;
            value       <= 16'h0000;
            value_valid <= 1'b0;
            bad_pattern <= 1'b0;
        end else begin
            s_seg       <= seg_in;
            stable_cnt  <= cnt_next;
            bad_pattern <= !word_ok;
            if (commit) begin
                value       <= word;
                value_valid <= 1'b1;
            end
        end
    end

    // Read handshake: rd_valid means rd_data holds the oldest queued word; it
    // is consumed on any rising edge with rd_valid & rd_ready, and rd_data
    // stays put while rd_ready is low.
    logic [15:0]   mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          pop;
    logic          full;
    logic          push;
    logic          drop;

    assign pop  = rd_valid && rd_ready;
    assign full = (count == FULL);
    assign push = commit && (!full || pop);
    assign drop = commit && full && !pop;

    assign rd_valid = (count != '0);
    assign rd_data  = rd_valid ? mem[rd_ptr] : 16'h0000;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= word;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            overflow_cnt <= 8'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop && (overflow_cnt != 8'hFF)) begin
                overflow_cnt <= overflow_cnt + 8'd1;
            end
        end
    end

endmodule

// File: doc/seg_monitor.md
# seg_monitor

Receive-side counterpart of the datapath's 7-segment display outputs: samples the four segment buses, decodes each pattern back to a hex nibble, waits for the 16-bit word to be stable, and commits each new value into a small FIFO for a consumer (bench scoreboard, UART dumper) with a valid/ready handshake. It sits beside the datapath on the same clock and turns the display into a checkable 16-bit value stream.

## Interface

- STABLE_CYCLES, 3: consecutive identical samples required before a word is committed (range 1–15).
- DEPTH, 4: FIFO entries (power of two, 2–16).
- SEG_ACTIVE_LOW, 1: 1 = segment lit when bit is 0 (inputs inverted before decoding).
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- seg0  input  7  digit 0 pattern (least significant nibble), bit0 = a … bit6 = g.
- seg1  input  7  digit 1 pattern.
- seg2  input  7  digit 2 pattern.
- seg3  input  7  digit 3 pattern (most significant nibble).
- value  output  16  last committed word {d3,d2,d1,d0}.
- value_valid  output  1  high once any word has been committed since reset.
- bad_pattern  output  1  one-cycle pulse when the sampled word contains an undecodable digit.
- rd_data  output  16  FIFO head.
- rd_valid  output  1  FIFO non-empty.
- rd_ready  input  1  consumer accepts head when rd_valid & rd_ready.
- overflow_cnt  output  8  saturating count of commits dropped because FIFO full.

## Operation

- Sample: all four seg buses registered every cycle into s_seg (one register stage, no other synchronisation).
- Decode (after optional inversion), active-high gfedcba: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71. Any other pattern (blank included) = invalid digit.
- Word invalid if any digit invalid: bad_pattern pulses on each such sampled cycle, stable_cnt cleared to 0, no commit.
- Stability: stable_cnt counts cycles s_seg equals its previous sample; cleared on any change; saturates at STABLE_CYCLES.
- Commit: on the edge where stable_cnt reaches STABLE_CYCLES and (value_valid == 0 or word != value): value <= word, value_valid <= 1, word pushed to FIFO. A stable word equal to value never commits again; A→B→A commits three times.
- FIFO: push on commit, pop on rd_valid & rd_ready. Full with pop in same cycle: both occur, no drop. Full without pop: word dropped, overflow_cnt += 1 (saturates at 255); value still updates. Empty: rd_valid = 0, rd_data = 0.
- Pointers wrap modulo DEPTH; count register of width log2(DEPTH)+1 distinguishes full/empty.

## Timing

- Reset (async assert, sync effect on release): s_seg = 0, stable_cnt = 0, value = 0, value_valid = 0, bad_pattern = 0, FIFO empty, rd_data = 0, rd_valid = 0, overflow_cnt = 0. Reset mid-operation discards FIFO contents and any partial stability count.
- Latency: inputs valid before edge E are in s_seg after E; commit occurs at edge E+STABLE_CYCLES; value/rd_valid visible after that edge (STABLE_CYCLES+1 edges from first sample).
- bad_pattern asserted the cycle after the invalid pattern is sampled, for one cycle per invalid sample.
- Pop takes effect on the accepting edge; next head on rd_data the following cycle. Push to empty FIFO: rd_valid high the cycle after commit edge.
- Simultaneous push to empty and pop: impossible (rd_valid low); no bypass path.

## Structure

- Shared package: decode constants SEG_0…SEG_F, segment bit-index constants, SEG_WIDTH = 7.
- Sub-module seg7_decode: combinational 7-bit pattern -> {valid, nibble}, instantiated four times. FIFO stays inline.

## Test plan

- Reset, seg3..0 = 79,24,30,19 (active-low "1234") held -> value = 0x1234, value_valid = 1 and rd_data = 0x1234 exactly STABLE_CYCLES+1 edges later; one FIFO entry.
- Toggle seg0 between "4" and "5" every cycle for 10 cycles then hold "5" -> no commit during toggling; single commit of 0x1235 after hold.
- Set seg2 = 7F (blank, active-low) -> bad_pattern pulses every sampled cycle, value unchanged, no push.
- rd_ready = 0, commit 6 distinct words with DEPTH = 4 -> FIFO holds first 4, overflow_cnt = 2, value = 6th word; drain yields words 1–4 in order.
- FIFO full, new commit on same edge as pop -> no drop, overflow_cnt unchanged, order preserved.
- Assert rst while FIFO holds 3 entries and stability count is mid-way -> all outputs 0 immediately; after release, held word commits STABLE_CYCLES+1 edges later.
